// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcodes, FSM states and the flag bundle.
// No logic beyond the is_iter() opcode classifier.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_A    = 4'h0,
        OP_B    = 4'h1,
        OP_INCA = 4'h2,
        OP_INCB = 4'h3,
        OP_ADD  = 4'h4,
        OP_SUB  = 4'h5,
        OP_AND  = 4'h6,
        OP_OR   = 4'h7,
        OP_SHR1 = 4'h8,
        OP_SHL1 = 4'h9,
        OP_XOR  = 4'hA,
        OP_LSR  = 4'hB,
        OP_LSL  = 4'hC,
        OP_MUL  = 4'hD,
        OP_ASR  = 4'hE,
        OP_ILL  = 4'hF
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    typedef struct packed {
        logic cf;
        logic zf;
        logic nf;
        logic vf;
        logic err;
    } alu_flags_t;

    // One bit per opcode: set for the ops that iterate in BUSY (LSR, LSL, MUL, ASR).
    localparam logic [15:0] OP_ITER_MASK = 16'b0111_1000_0000_0000;

    function automatic logic is_iter(input logic [3:0] op);
        return OP_ITER_MASK[op];
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath (ops 0000-1010 and illegal 1111), purely combinational.
// Iterative opcodes pass A through with cf=0, which is exactly the zero-shift result.
module alu_comb import alu_pkg::*; #(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] c_o,
    output alu_flags_t       flags_o
);

    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] c;
    logic             cf;
    logic             vf;
    logic             err;

    always_comb begin
        ext = '0;
        c   = a_i;
        cf  = 1'b0;
        vf  = 1'b0;
        err = 1'b0;
        case (alu_op_e'(op_i))
            OP_A:    c = a_i;
            OP_B:    c = b_i;
            OP_INCA: begin
                ext = {1'b0, a_i} + {{WIDTH{1'b0}}, 1'b1};
                c   = ext[WIDTH-1:0];
                cf  = ext[WIDTH];
                vf  = ~a_i[WIDTH-1] & c[WIDTH-1];
            end
            OP_INCB: begin
                ext = {1'b0, b_i} + {{WIDTH{1'b0}}, 1'b1};
                c   = ext[WIDTH-1:0];
                cf  = ext[WIDTH];
                vf  = ~b_i[WIDTH-1] & c[WIDTH-1];
            end
            OP_ADD: begin
                ext = {1'b0, a_i} + {1'b0, b_i};
                c   = ext[WIDTH-1:0];
                cf  = ext[WIDTH];
                vf  = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (c[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SUB: begin
                // The borrow out of the extended subtraction is the unsigned A<B.
                ext = {1'b0, a_i} - {1'b0, b_i};
                c   = ext[WIDTH-1:0];
                cf  = ext[WIDTH];
                vf  = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (c[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_AND:  c = a_i & b_i;
            OP_OR:   c = a_i | b_i;
            OP_XOR:  c = a_i ^ b_i;
            OP_SHR1: begin
                c  = {1'b0, a_i[WIDTH-1:1]};
                cf = a_i[0];
            end
            OP_SHL1: begin
                c  = {a_i[WIDTH-2:0], 1'b0};
                cf = a_i[WIDTH-1];
            end
            OP_ILL: begin
                c   = '0;
                err = 1'b1;
            end
            default: c = a_i;
        endcase
    end

    assign c_o         = c;
    assign flags_o.cf  = cf;
    assign flags_o.zf  = (c == '0) && !err;
    assign flags_o.nf  = c[WIDTH-1];
    assign flags_o.vf  = vf;
    assign flags_o.err = err;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: 1-cycle ops, k+1-cycle shifts (k=min(B,WIDTH)), WIDTH+1-cycle multiply.
// Result holds in DONE until out_ready; in_ready only in IDLE; abort drops BUSY/DONE work.
module alu_mc import alu_pkg::*; #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             cf,
    output logic             zf,
    output logic             nf,
    output logic             vf,
    output logic             err
);

    localparam int CNTW = $clog2(WIDTH) + 1;
    localparam int W2   = 2 * WIDTH;

    alu_state_e       state_q, state_d;
    alu_op_e          op_q, op_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] mpl_q, mpl_d;
    logic [W2-1:0]    mcand_q, mcand_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] c_q, c_d;
    alu_flags_t       flg_q, flg_d;

    logic [WIDTH-1:0] comb_c;
    alu_flags_t       comb_flg;
    logic [CNTW-1:0]  k;
    logic [WIDTH-1:0] sh_nxt;
    logic             sh_out;
    logic [W2-1:0]    acc_nxt;
    logic [WIDTH-1:0] res_c;
    logic             res_cf;

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .op_i    (op),
        .a_i     (a),
        .b_i     (b),
        .c_o     (comb_c),
        .flags_o (comb_flg)
    );

    assign k = (b >= WIDTH'(WIDTH)) ? CNTW'(WIDTH) : b[CNTW-1:0];

    // One iteration step of whichever shift or multiply is in flight.
    always_comb begin
        sh_nxt = {1'b0, sh_q[WIDTH-1:1]};
        sh_out = sh_q[0];
        case (op_q)
            OP_LSL: begin
                sh_nxt = {sh_q[WIDTH-2:0], 1'b0};
                sh_out = sh_q[WIDTH-1];
            end
            OP_ASR:  sh_nxt = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
            default: ;
        endcase
        acc_nxt = mpl_q[0] ? (acc_q + mcand_q) : acc_q;
        res_c   = (op_q == OP_MUL) ? acc_nxt[WIDTH-1:0] : sh_nxt;
        res_cf  = (op_q == OP_MUL) ? |acc_nxt[W2-1:WIDTH] : sh_out;
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sh_d    = sh_q;
        mpl_d   = mpl_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        flg_d   = flg_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d = alu_op_e'(op);
                    if (is_iter(op) && ((alu_op_e'(op) == OP_MUL) || (k != '0))) begin
                        state_d = ST_BUSY;
                        cnt_d   = (alu_op_e'(op) == OP_MUL) ? CNTW'(WIDTH) : k;
                        sh_d    = a;
                        mpl_d   = b;
                        mcand_d = {{WIDTH{1'b0}}, a};
                        acc_d   = '0;
                    end else begin
                        state_d = ST_DONE;
                        c_d     = comb_c;
                        flg_d   = comb_flg;
                    end
                end
            end
            ST_BUSY: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    sh_d    = sh_nxt;
                    acc_d   = acc_nxt;
                    mcand_d = mcand_q << 1;
                    mpl_d   = mpl_q >> 1;
                    cnt_d   = cnt_q - 1'b1;
                    if (cnt_q == CNTW'(1)) begin
                        state_d   = ST_DONE;
                        c_d       = res_c;
                        flg_d.cf  = res_cf;
                        flg_d.zf  = (res_c == '0);
                        flg_d.nf  = res_c[WIDTH-1];
                        flg_d.vf  = 1'b0;
                        flg_d.err = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                if (abort || out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_A;
            sh_q    <= '0;
            mpl_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            c_q     <= '0;
            flg_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sh_q    <= sh_d;
            mpl_q   <= mpl_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            flg_q   <= flg_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign c         = c_q;
    assign cf        = flg_q.cf;
    assign zf        = flg_q.zf;
    assign nf        = flg_q.nf;
    assign vf        = flg_q.vf;
    assign err       = flg_q.err;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc at WIDTH=8: vector table through a scoreboard queue, then
// hand-written backpressure, abort and mid-operation reset sequences.
module tb_alu_mc;
    import alu_pkg::*;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic       cf;
        logic       zf;
        logic       nf;
        logic       vf;
        logic       err;
        logic       zf_dc;
        int         lat;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       abort = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] op = 4'h0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] c;
    logic       cf, zf, nf, vf, err;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    vec_t sb[$];

    alu_mc #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .cf        (cf),
        .zf        (zf),
        .nf        (nf),
        .vf        (vf),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] o, input logic [7:0] va, input logic [7:0] vb,
                                input logic [7:0] vc, input logic vcf, input logic vzf,
                                input logic vnf, input logic vvf, input logic verr, input int vlat);
        vec_t v;
        v.op = o; v.a = va; v.b = vb; v.c = vc;
        v.cf = vcf; v.zf = vzf; v.nf = vnf; v.vf = vvf; v.err = verr;
        v.zf_dc = 1'b0; v.lat = vlat;
        return v;
    endfunction

    // Drive one op, push its expectation, then pop and compare when out_valid rises.
    task automatic do_op(input vec_t v, input logic with_abort);
        int   lat;
        vec_t e;
        string t;
        @(negedge clk);
        chk("in_ready_before_op", in_ready, 1);
        op = v.op; a = v.a; b = v.b; in_valid = 1'b1; abort = with_abort;
        sb.push_back(v);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        abort = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        e = sb.pop_front();
        t = $sformatf("op%h a=%h b=%h", e.op, e.a, e.b);
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL timeout %s: out_valid never rose", t);
        end else begin
            chk({t, " latency"}, lat, e.lat);
            chk({t, " c"}, c, e.c);
            chk({t, " cf"}, cf, e.cf);
            if (!e.zf_dc) chk({t, " zf"}, zf, e.zf);
            chk({t, " nf"}, nf, e.nf);
            chk({t, " vf"}, vf, e.vf);
            chk({t, " err"}, err, e.err);
        end
    endtask

    initial begin
        vec_t iv;
        logic ov_seen;

        //              op       a      b      c      cf zf nf vf er lat
        vecs.push_back(mk(OP_ADD,  8'hFF, 8'h01, 8'h00, 1, 1, 0, 0, 0, 1));
        vecs.push_back(mk(OP_SUB,  8'h10, 8'h20, 8'hF0, 1, 0, 1, 0, 0, 1));
        vecs.push_back(mk(OP_INCA, 8'h7F, 8'h00, 8'h80, 0, 0, 1, 1, 0, 1));
        vecs.push_back(mk(OP_MUL,  8'h10, 8'h10, 8'h00, 1, 1, 0, 0, 0, 9));
        vecs.push_back(mk(OP_MUL,  8'h0F, 8'h11, 8'hFF, 0, 0, 1, 0, 0, 9));
        vecs.push_back(mk(OP_LSL,  8'h81, 8'd3,  8'h08, 0, 0, 0, 0, 0, 4));
        vecs.push_back(mk(OP_ASR,  8'h80, 8'd2,  8'hE0, 0, 0, 1, 0, 0, 3));
        vecs.push_back(mk(OP_LSR,  8'hFF, 8'd20, 8'h00, 1, 1, 0, 0, 0, 9));
        vecs.push_back(mk(OP_XOR,  8'hA5, 8'hFF, 8'h5A, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(OP_SHL1, 8'h81, 8'h00, 8'h02, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(OP_SHR1, 8'h03, 8'h00, 8'h01, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(OP_LSR,  8'h9C, 8'd0,  8'h9C, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(OP_ADD,  8'h7F, 8'h01, 8'h80, 0, 0, 1, 1, 0, 1));
        vecs.push_back(mk(OP_SUB,  8'h80, 8'h01, 8'h7F, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk(OP_A,    8'h5C, 8'h33, 8'h5C, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(OP_B,    8'h5C, 8'h00, 8'h00, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(OP_INCB, 8'h00, 8'hFF, 8'h00, 1, 1, 0, 0, 0, 1));
        vecs.push_back(mk(OP_AND,  8'hF0, 8'h3C, 8'h30, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(OP_OR,   8'hF0, 8'h0F, 8'hFF, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(OP_ASR,  8'h40, 8'd8,  8'h00, 0, 1, 0, 0, 0, 9));
        vecs.push_back(mk(OP_LSL,  8'h01, 8'd8,  8'h00, 1, 1, 0, 0, 0, 9));
        iv = mk(OP_ILL, 8'h12, 8'h34, 8'h00, 0, 0, 0, 0, 1, 1);
        iv.zf_dc = 1'b1;
        vecs.push_back(iv);

        // Reset state.
        #12;
        chk("reset c", c, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset flags", {cf, zf, nf, vf, err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready after reset", in_ready, 1);

        foreach (vecs[i]) do_op(vecs[i], 1'b0);

        // Backpressure: result held while a second request waits.
        @(negedge clk);
        out_ready = 1'b0;
        op = OP_ADD; a = 8'h12; b = 8'h34; in_valid = 1'b1;
        @(negedge clk);
        op = OP_OR; a = 8'h0F; b = 8'hF0;
        chk("bp out_valid", out_valid, 1);
        chk("bp c first", c, 8'h46);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp hold%0d c", i), c, 8'h46);
            chk($sformatf("bp hold%0d flags", i), {cf, zf, nf, vf, err}, 0);
            chk($sformatf("bp hold%0d in_ready", i), in_ready, 0);
            chk($sformatf("bp hold%0d out_valid", i), out_valid, 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp released in_ready", in_ready, 1);
        chk("bp released out_valid", out_valid, 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp second out_valid", out_valid, 1);
        chk("bp second c", c, 8'hFF);

        // Abort together with in_valid in IDLE: op is still accepted.
        do_op(mk(OP_ADD, 8'h01, 8'h02, 8'h03, 0, 0, 0, 0, 0, 1), 1'b1);

        // Abort in cycle 4 of a multiply.
        @(negedge clk);
        op = OP_MUL; a = 8'h03; b = 8'h05; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ov_seen = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            ov_seen |= out_valid;
        end
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort in_ready", in_ready, 1);
        chk("abort c unchanged", c, 8'h03);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            ov_seen |= out_valid;
        end
        chk("abort out_valid never", ov_seen, 0);

        // Make the flags non-zero, then reset in the middle of a shift.
        do_op(mk(OP_SUB, 8'h01, 8'h02, 8'hFF, 1, 0, 1, 0, 0, 1), 1'b0);
        @(negedge clk);
        op = OP_LSL; a = 8'h01; b = 8'd8; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset c", c, 0);
        chk("midreset out_valid", out_valid, 0);
        chk("midreset flags", {cf, zf, nf, vf, err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midreset in_ready", in_ready, 1);
        do_op(mk(OP_ADD, 8'h20, 8'h22, 8'h42, 0, 0, 0, 0, 0, 1), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
